// File: rtl/wb_arbiter_n.sv
// N-master, single-slave Wishbone arbiter with fixed-priority or round-robin selection,
// whole-burst grant hold and a per-transfer ack watchdog.
module wb_arbiter_n #(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned SEL_W          = 3,
  parameter int unsigned RR_MODE        = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      wb_clk,
  input  logic                      wb_rst,
  input  logic [32*NUM_MASTERS-1:0] m_adr_i,
  input  logic [32*NUM_MASTERS-1:0] m_dat_i,
  input  logic [4*NUM_MASTERS-1:0]  m_sel_i,
  input  logic [NUM_MASTERS-1:0]    m_cyc_i,
  input  logic [NUM_MASTERS-1:0]    m_stb_i,
  input  logic [NUM_MASTERS-1:0]    m_we_i,
  output logic [31:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]    m_ack_o,
  output logic [NUM_MASTERS-1:0]    m_err_o,
  output logic [31:0]               s_adr_o,
  output logic [31:0]               s_dat_o,
  output logic [3:0]                s_sel_o,
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  output logic                      s_we_o,
  input  logic [31:0]               s_dat_i,
  input  logic                      s_ack_i,
  input  logic                      s_err_i,
  output logic [SEL_W-1:0]          mst_sel,
  output logic                      gnt_valid
);

  localparam int unsigned      CNT_W    = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_MASTERS - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_n;
  logic [SEL_W-1:0] last, last_n, sel_n, win;
  logic             gnt_n, found;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             fire_pend, fire_n, to_fire, to_kill, kill_n;
  logic             busy, stall;
  logic [31:0]      cur_adr, cur_dat;
  logic [3:0]       cur_sel;
  logic             cur_cyc, cur_stb, cur_we;
  int unsigned      cand;

  always_comb begin
    cur_adr = m_adr_i[31:0];
    cur_dat = m_dat_i[31:0];
    cur_sel = m_sel_i[3:0];
    cur_cyc = 1'b0;
    cur_stb = 1'b0;
    cur_we  = 1'b0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      if (mst_sel == SEL_W'(k)) begin
        cur_adr = m_adr_i[32*k +: 32];
        cur_dat = m_dat_i[32*k +: 32];
        cur_sel = m_sel_i[4*k +: 4];
        cur_cyc = m_cyc_i[k];
        cur_stb = m_stb_i[k];
        cur_we  = m_we_i[k];
      end
    end
  end

  // Candidate order starts after `last` in RR mode, at index 0 otherwise.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = 0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      cand = (RR_MODE != 0) ? (32'(last) + 1 + i) % NUM_MASTERS : i;
      for (int unsigned j = 0; j < NUM_MASTERS; j++) begin
        if (!found && j == cand && m_cyc_i[j]) begin
          found = 1'b1;
          win   = SEL_W'(j);
        end
      end
    end
  end

  assign busy    = (state == BUSY);
  assign to_fire = fire_pend & ~s_ack_i;
  assign s_cyc_o = busy & cur_cyc & ~to_kill;
  assign s_stb_o = busy & cur_stb & ~to_kill;
  assign s_we_o  = busy & cur_we;
  assign s_adr_o = busy ? cur_adr : m_adr_i[31:0];
  assign s_dat_o = busy ? cur_dat : m_dat_i[31:0];
  assign s_sel_o = busy ? cur_sel : m_sel_i[3:0];
  assign m_dat_o = s_dat_i;
  assign stall   = s_stb_o & ~s_ack_i & ~s_err_i;

  always_comb begin
    m_ack_o = '0;
    m_err_o = '0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      if (busy && mst_sel == SEL_W'(k)) begin
        m_ack_o[k] = s_ack_i;
        m_err_o[k] = s_err_i | to_fire;
      end
    end
  end

  always_comb begin
    state_n = state;
    sel_n   = mst_sel;
    gnt_n   = gnt_valid;
    last_n  = last;
    cnt_n   = cnt;
    fire_n  = 1'b0;
    kill_n  = to_kill;
    unique case (state)
      IDLE: begin
        cnt_n  = '0;
        kill_n = 1'b0;
        if (found) begin
          state_n = BUSY;
          sel_n   = win;
          gnt_n   = 1'b1;
          last_n  = win;
        end
      end
      BUSY: begin
        if (!cur_cyc) begin
          state_n = IDLE;
          gnt_n   = 1'b0;
          cnt_n   = '0;
          kill_n  = 1'b0;
        end else if (TIMEOUT_CYCLES != 0) begin
          // The fire cycle itself is not counted; a same-cycle ack cancels the kill.
          if (to_fire) begin
            kill_n = 1'b1;
            cnt_n  = '0;
          end else if (s_ack_i || s_err_i || fire_pend) begin
            cnt_n = '0;
          end else if (stall) begin
            if (cnt == CNT_LAST) begin
              fire_n = 1'b1;
              cnt_n  = '0;
            end else begin
              cnt_n = cnt + CNT_W'(1);
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state     <= IDLE;
      mst_sel   <= '0;
      gnt_valid <= 1'b0;
      last      <= SEL_LAST;
      cnt       <= '0;
      fire_pend <= 1'b0;
      to_kill   <= 1'b0;
    end else begin
      state     <= state_n;
      mst_sel   <= sel_n;
      gnt_valid <= gnt_n;
      last      <= last_n;
      cnt       <= cnt_n;
      fire_pend <= fire_n;
      to_kill   <= kill_n;
    end
  end

endmodule

// File: tb/tb_wb_arbiter_n.sv
// Scoreboard bench: two arbiters (fixed priority without watchdog, round-robin with an
// 8-cycle watchdog) driven by random masters and slaves, checked against a behavioural model.
module tb_wb_arbiter_n;

  localparam int N      = 4;
  localparam int CYCLES = 4200;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [32*N-1:0] m_adr [2];
  logic [32*N-1:0] m_dat [2];
  logic [4*N-1:0]  m_sel [2];
  logic [N-1:0]    m_cyc [2];
  logic [N-1:0]    m_stb [2];
  logic [N-1:0]    m_we  [2];
  logic [31:0]     s_dat_in [2];
  logic            s_ack [2];
  logic            s_err [2];

  logic [31:0]     o_mdat [2];
  logic [N-1:0]    o_ack  [2];
  logic [N-1:0]    o_err  [2];
  logic [31:0]     o_sadr [2];
  logic [31:0]     o_sdat [2];
  logic [3:0]      o_ssel [2];
  logic            o_scyc [2];
  logic            o_sstb [2];
  logic            o_swe  [2];
  logic [2:0]      o_msel [2];
  logic            o_gnt  [2];

  wb_arbiter_n #(.NUM_MASTERS(N), .SEL_W(3), .RR_MODE(0), .TIMEOUT_CYCLES(0)) dut0 (
    .wb_clk(clk), .wb_rst(rst),
    .m_adr_i(m_adr[0]), .m_dat_i(m_dat[0]), .m_sel_i(m_sel[0]),
    .m_cyc_i(m_cyc[0]), .m_stb_i(m_stb[0]), .m_we_i(m_we[0]),
    .m_dat_o(o_mdat[0]), .m_ack_o(o_ack[0]), .m_err_o(o_err[0]),
    .s_adr_o(o_sadr[0]), .s_dat_o(o_sdat[0]), .s_sel_o(o_ssel[0]),
    .s_cyc_o(o_scyc[0]), .s_stb_o(o_sstb[0]), .s_we_o(o_swe[0]),
    .s_dat_i(s_dat_in[0]), .s_ack_i(s_ack[0]), .s_err_i(s_err[0]),
    .mst_sel(o_msel[0]), .gnt_valid(o_gnt[0])
  );

  wb_arbiter_n #(.NUM_MASTERS(N), .SEL_W(3), .RR_MODE(1), .TIMEOUT_CYCLES(8)) dut1 (
    .wb_clk(clk), .wb_rst(rst),
    .m_adr_i(m_adr[1]), .m_dat_i(m_dat[1]), .m_sel_i(m_sel[1]),
    .m_cyc_i(m_cyc[1]), .m_stb_i(m_stb[1]), .m_we_i(m_we[1]),
    .m_dat_o(o_mdat[1]), .m_ack_o(o_ack[1]), .m_err_o(o_err[1]),
    .s_adr_o(o_sadr[1]), .s_dat_o(o_sdat[1]), .s_sel_o(o_ssel[1]),
    .s_cyc_o(o_scyc[1]), .s_stb_o(o_sstb[1]), .s_we_o(o_swe[1]),
    .s_dat_i(s_dat_in[1]), .s_ack_i(s_ack[1]), .s_err_i(s_err[1]),
    .mst_sel(o_msel[1]), .gnt_valid(o_gnt[1])
  );

  typedef struct {
    int          d;
    logic        gnt;
    logic [2:0]  msel;
    logic        scyc, sstb, swe;
    logic [31:0] sadr, sdat;
    logic [3:0]  ssel;
    logic [N-1:0] ack, err;
    logic [31:0] mdat;
  } exp_t;

  exp_t exp_q[$];
  int   gq0[$];
  int   gq1[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: owner of the slave (-1 when free) and watchdog bookkeeping.
  int   rr_of  [2] = '{0, 1};
  int   tmo_of [2] = '{0, 8};
  int   owner [2];
  int   sel   [2];
  int   last  [2];
  int   stalls[2];
  bit   killed[2];
  bit   fire_due[2];

  bit          want  [2][N];
  int          beats [2][N];
  logic [31:0] addr  [2][N];
  logic [N-1:0] last_ack [2];
  logic [N-1:0] last_err [2];
  int          stall_left [2];

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d got=%h want=%h at %0t", nm, d, act, exp, $time);
    end
  endtask

  function automatic int pick(input int rr, input int lst, input logic [N-1:0] req);
    for (int i = 0; i < N; i++) begin
      int c;
      c = (rr != 0) ? (lst + 1 + i) % N : i;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  task automatic step_model();
    for (int d = 0; d < 2; d++) begin
      int o;
      int w;
      o = owner[d];
      if (rst) begin
        owner[d] = -1; sel[d] = 0; last[d] = N - 1;
        stalls[d] = 0; killed[d] = 0; fire_due[d] = 0;
      end else if (o < 0) begin
        w = pick(rr_of[d], last[d], m_cyc[d]);
        if (w >= 0) begin
          owner[d] = w; sel[d] = w; last[d] = w;
          stalls[d] = 0; killed[d] = 0; fire_due[d] = 0;
          if (d == 0) gq0.push_back(w);
          else        gq1.push_back(w);
        end
      end else if (!m_cyc[d][o]) begin
        owner[d] = -1; stalls[d] = 0; killed[d] = 0; fire_due[d] = 0;
      end else if (tmo_of[d] != 0) begin
        if (fire_due[d]) begin
          if (!s_ack[d]) killed[d] = 1;
          fire_due[d] = 0;
          stalls[d] = 0;
        end else if (s_ack[d] || s_err[d]) begin
          stalls[d] = 0;
        end else if (m_stb[d][o] && !killed[d]) begin
          stalls[d]++;
          if (stalls[d] == tmo_of[d]) begin
            fire_due[d] = 1;
            stalls[d] = 0;
          end
        end
      end
    end
  endtask

  task automatic drive_masters(input int phase);
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < N; k++) begin
        if (want[d][k]) begin
          if (last_err[d][k]) want[d][k] = 0;
          else if (last_ack[d][k]) begin
            beats[d][k]--;
            addr[d][k] = addr[d][k] + 32'd4;
            if (beats[d][k] <= 0) want[d][k] = 0;
          end else if (phase == 1 && $urandom_range(0, 63) == 0) want[d][k] = 0;
        end else if (phase == 0 || phase == 2 || (phase == 1 && $urandom_range(0, 2) == 0)) begin
          want[d][k]  = 1;
          beats[d][k] = (phase == 0) ? 1 : (phase == 2) ? 1000 : int'($urandom_range(1, 4));
          addr[d][k]  = $urandom & 32'hFFFF_FFFC;
        end
        m_cyc[d][k] = want[d][k];
        m_stb[d][k] = want[d][k] && (phase != 1 || $urandom_range(0, 3) != 0);
        m_we[d][k]  = 1'($urandom_range(0, 1));
        m_adr[d][32*k +: 32] = addr[d][k];
        m_dat[d][32*k +: 32] = $urandom;
        m_sel[d][4*k +: 4]   = 4'($urandom_range(0, 15));
      end
    end
  endtask

  task automatic predict(input int phase);
    for (int d = 0; d < 2; d++) begin
      exp_t e;
      bit   busy;
      int   oi;
      busy = owner[d] >= 0;
      oi   = busy ? owner[d] : 0;
      e.d    = d;
      e.gnt  = busy;
      e.msel = 3'(sel[d]);
      e.scyc = busy && m_cyc[d][oi] && !killed[d];
      e.sstb = busy && m_stb[d][oi] && !killed[d];
      e.swe  = busy && m_we[d][oi];
      e.sadr = m_adr[d][32*oi +: 32];
      e.sdat = m_dat[d][32*oi +: 32];
      e.ssel = m_sel[d][4*oi +: 4];
      s_dat_in[d] = $urandom;
      if (phase == 2) begin
        s_ack[d] = 0; s_err[d] = 0;
      end else if (stall_left[d] > 0) begin
        stall_left[d]--;
        s_ack[d] = 0; s_err[d] = 0;
      end else begin
        if ($urandom_range(0, 7) == 0) stall_left[d] = $urandom_range(1, 12);
        s_ack[d] = e.sstb && ($urandom_range(0, 1) == 1);
        s_err[d] = e.sstb && !s_ack[d] && ($urandom_range(0, 31) == 0);
      end
      e.ack = '0;
      e.err = '0;
      if (busy) begin
        e.ack[oi] = s_ack[d];
        e.err[oi] = s_err[d] || (fire_due[d] && !s_ack[d]);
      end
      e.mdat = s_dat_in[d];
      last_ack[d] = e.ack;
      last_err[d] = e.err;
      exp_q.push_back(e);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      m_adr[d] = '0; m_dat[d] = '0; m_sel[d] = '0;
      m_cyc[d] = '0; m_stb[d] = '0; m_we[d] = '0;
      s_dat_in[d] = '0; s_ack[d] = 0; s_err[d] = 0;
      owner[d] = -1; sel[d] = 0; last[d] = N - 1;
      stalls[d] = 0; killed[d] = 0; fire_due[d] = 0;
      last_ack[d] = '0; last_err[d] = '0; stall_left[d] = 0;
      for (int k = 0; k < N; k++) begin
        want[d][k] = 0; beats[d][k] = 0; addr[d][k] = '0;
      end
    end
    for (int cy = 0; cy < CYCLES; cy++) begin
      int phase;
      @(posedge clk);
      #1;
      step_model();
      phase = (cy < 62) ? 0 : (cy < 3060) ? 1 : (cy < 4100) ? 2 : 3;
      rst = (cy < 2) || (phase == 1 && $urandom_range(0, 299) == 0);
      drive_masters(phase);
      predict(phase);
    end
    @(negedge clk);
    #1;
    chk("grant_queue0_drained", 0, 32'(gq0.size()), 32'd0);
    chk("grant_queue1_drained", 1, 32'(gq1.size()), 32'd0);
    chk("expect_queue_drained", 0, 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  logic prev_gnt [2] = '{1'b0, 1'b0};

  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("gnt_valid", e.d, 32'(o_gnt[e.d]),  32'(e.gnt));
        chk("mst_sel",   e.d, 32'(o_msel[e.d]), 32'(e.msel));
        chk("s_cyc",     e.d, 32'(o_scyc[e.d]), 32'(e.scyc));
        chk("s_stb",     e.d, 32'(o_sstb[e.d]), 32'(e.sstb));
        chk("s_we",      e.d, 32'(o_swe[e.d]),  32'(e.swe));
        chk("s_adr",     e.d, o_sadr[e.d],      e.sadr);
        chk("s_dat",     e.d, o_sdat[e.d],      e.sdat);
        chk("s_sel",     e.d, 32'(o_ssel[e.d]), 32'(e.ssel));
        chk("m_ack",     e.d, 32'(o_ack[e.d]),  32'(e.ack));
        chk("m_err",     e.d, 32'(o_err[e.d]),  32'(e.err));
        chk("m_dat",     e.d, o_mdat[e.d],      e.mdat);
      end
      for (int d = 0; d < 2; d++) begin
        if (o_gnt[d] === 1'b1 && prev_gnt[d] !== 1'b1) begin
          int w;
          w = -1;
          if (d == 0 && gq0.size() > 0) w = gq0.pop_front();
          if (d == 1 && gq1.size() > 0) w = gq1.pop_front();
          chk("grant_order", d, 32'(o_msel[d]), 32'(w));
        end
        prev_gnt[d] = o_gnt[d];
      end
    end
  end

endmodule
